// File: rtl/ddr_resp_pkg.sv
// ============================================================================
// ddr_resp_pkg : shared widths, timeout default and FSM encoding
// Rev 1.0
// ============================================================================
`default_nettype none

package ddr_resp_pkg;

    localparam int DDR_ADDR_W  = 27;
    localparam int DDR_DATA_W  = 32;
    localparam int DDR_TIMEOUT = 1023;

    localparam logic [2:0] C_ST_INIT    = 3'd0;
    localparam logic [2:0] C_ST_IDLE    = 3'd1;
    localparam logic [2:0] C_ST_RD_CMD  = 3'd2;
    localparam logic [2:0] C_ST_RD_WAIT = 3'd3;
    localparam logic [2:0] C_ST_WR_CMD  = 3'd4;
    localparam logic [2:0] C_ST_DONE    = 3'd5;

    typedef enum logic [2:0] {
        ST_INIT    = C_ST_INIT,
        ST_IDLE    = C_ST_IDLE,
        ST_RD_CMD  = C_ST_RD_CMD,
        ST_RD_WAIT = C_ST_RD_WAIT,
        ST_WR_CMD  = C_ST_WR_CMD,
        ST_DONE    = C_ST_DONE
    } state_t;

endpackage

`default_nettype wire

// File: rtl/ddr_req_responder_timeout.sv
// ============================================================================
// ddr_timeout_ctr : saturating transaction-age counter with expiry flag
// Rev 1.0
// ============================================================================
`default_nettype none

module ddr_timeout_ctr #(
    parameter int MAX = 1023
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clear,
    output logic expired
);

    localparam int              CNT_W  = $clog2(MAX + 1);
    localparam logic [CNT_W-1:0] C_MAX  = CNT_W'(MAX);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(MAX - 1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (en && (r_count != C_MAX)) begin
            r_count <= r_count + 1'b1;
        end
    end

    // Fires in the MAX-th enabled cycle, i.e. as the count reaches MAX
    assign expired = en && (r_count >= C_LAST);

endmodule

`default_nettype wire

// File: rtl/ddr_req_responder.sv
// ============================================================================
// ddr_req_responder : CPU level-request to single-word Avalon-MM bridge
// Optional DDR_RD_CACHE_EN adds a one-entry write-through last-read cache.
// Rev 1.0
// ============================================================================
`default_nettype none

module ddr_req_responder
    import ddr_resp_pkg::*;
#(
    parameter int ADDR_W  = DDR_ADDR_W,
    parameter int DATA_W  = DDR_DATA_W,
    parameter int TIMEOUT = DDR_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] write_data,
    input  logic              read_req,
    input  logic              write_req,
    output logic [DATA_W-1:0] read_data,
    output logic              waiting,
    output logic [ADDR_W-1:0] avl_address,
    output logic              avl_read,
    output logic              avl_write,
    output logic [DATA_W-1:0] avl_writedata,
    input  logic [DATA_W-1:0] avl_readdata,
    input  logic              avl_rdvalid,
    input  logic              avl_waitreq,
    input  logic              init_done,
    output logic              err
);

    state_t            r_state;
    state_t            w_next;
    logic              w_busy;
    logic              w_expired;
    logic              w_req;
    logic              w_hit;
    logic [DATA_W-1:0] w_hit_data;
    logic [DATA_W-1:0] r_read_data;

    assign w_req  = read_req | write_req;
    assign w_busy = (r_state == ST_RD_CMD) || (r_state == ST_RD_WAIT) || (r_state == ST_WR_CMD);

    ddr_timeout_ctr #(
        .MAX     (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .en      (w_busy),
        .clear   (w_next == ST_IDLE),
        .expired (w_expired)
    );

`ifdef DDR_RD_CACHE_EN
    logic              r_cache_valid;
    logic [ADDR_W-1:0] r_cache_tag;
    logic [DATA_W-1:0] r_cache_data;

    assign w_hit      = (r_state == ST_IDLE) && read_req && !write_req &&
                        r_cache_valid && (r_cache_tag == address);
    assign w_hit_data = r_cache_data;
    // A hit completes in the request cycle, so the cached word bypasses the register
    assign read_data  = w_hit ? r_cache_data : r_read_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cache_valid <= 1'b0;
            r_cache_tag   <= '0;
            r_cache_data  <= '0;
        end else if (w_expired) begin
            r_cache_valid <= 1'b0;
        end else if ((r_state == ST_RD_WAIT) && avl_rdvalid) begin
            r_cache_valid <= 1'b1;
            r_cache_tag   <= avl_address;
            r_cache_data  <= avl_readdata;
        end else if ((r_state == ST_WR_CMD) && !avl_waitreq &&
                     r_cache_valid && (r_cache_tag == avl_address)) begin
            r_cache_data  <= avl_writedata;
        end
    end
`else
    assign w_hit      = 1'b0;
    assign w_hit_data = '0;
    assign read_data  = r_read_data;
`endif

    always_comb begin
        w_next  = r_state;
        waiting = 1'b0;
        case (r_state)
            ST_INIT: begin
                waiting = 1'b1;
                if (init_done) w_next = ST_IDLE;
            end
            ST_IDLE: begin
                if (w_req && !w_hit) begin
                    waiting = 1'b1;
                    w_next  = write_req ? ST_WR_CMD : ST_RD_CMD;
                end
            end
            ST_RD_CMD: begin
                waiting = 1'b1;
                if (w_expired)         w_next = ST_DONE;
                else if (!avl_waitreq) w_next = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                waiting = 1'b1;
                if (w_expired || avl_rdvalid) w_next = ST_DONE;
            end
            ST_WR_CMD: begin
                waiting = 1'b1;
                if (w_expired || !avl_waitreq) w_next = ST_DONE;
            end
            ST_DONE: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next  = ST_INIT;
                waiting = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_INIT;
            r_read_data   <= '0;
            avl_read      <= 1'b0;
            avl_write     <= 1'b0;
            avl_address   <= '0;
            avl_writedata <= '0;
            err           <= 1'b0;
        end else begin
            r_state   <= w_next;
            // Strobes follow the command states; a timeout drops them with the state
            avl_read  <= (w_next == ST_RD_CMD);
            avl_write <= (w_next == ST_WR_CMD);
            if ((r_state == ST_IDLE) && w_req && !w_hit) begin
                avl_address   <= address;
                avl_writedata <= write_data;
            end
            if (w_expired) begin
                err <= 1'b1;
            end
            if ((r_state == ST_RD_WAIT) && avl_rdvalid && !w_expired) begin
                r_read_data <= avl_readdata;
            end else if (w_hit) begin
                r_read_data <= w_hit_data;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ddr_req_responder.sv
// ============================================================================
// tb_ddr_req_responder : directed self-checking bench, TIMEOUT reduced to 15
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_ddr_req_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [26:0] address;
    logic [31:0] write_data;
    logic        read_req;
    logic        write_req;
    logic [31:0] read_data;
    logic        waiting;
    logic [26:0] avl_address;
    logic        avl_read;
    logic        avl_write;
    logic [31:0] avl_writedata;
    logic [31:0] avl_readdata;
    logic        avl_rdvalid;
    logic        avl_waitreq;
    logic        init_done;
    logic        err;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    ddr_req_responder #(
        .ADDR_W        (27),
        .DATA_W        (32),
        .TIMEOUT       (15)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .address       (address),
        .write_data    (write_data),
        .read_req      (read_req),
        .write_req     (write_req),
        .read_data     (read_data),
        .waiting       (waiting),
        .avl_address   (avl_address),
        .avl_read      (avl_read),
        .avl_write     (avl_write),
        .avl_writedata (avl_writedata),
        .avl_readdata  (avl_readdata),
        .avl_rdvalid   (avl_rdvalid),
        .avl_waitreq   (avl_waitreq),
        .init_done     (init_done),
        .err           (err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; address = '0; write_data = '0; read_req = 1'b0; write_req = 1'b0;
        avl_readdata = '0; avl_rdvalid = 1'b0; avl_waitreq = 1'b0; init_done = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_waiting",   waiting,       1);
        chk("rst_avl_read",  avl_read,      0);
        chk("rst_avl_write", avl_write,     0);
        chk("rst_err",       err,           0);
        chk("rst_read_data", read_data,     0);
        chk("rst_avl_addr",  avl_address,   0);
        chk("rst_avl_wdata", avl_writedata, 0);

        // Calibration pending: request held, nothing reaches Avalon
        @(negedge clk);
        rst = 1'b0; read_req = 1'b1; address = 27'h0000123;
        for (int i = 0; i < 20; i++) begin
            #1;
            chk("init_hold", {waiting, avl_read, avl_write}, 3'b100);
            @(negedge clk);
        end
        init_done = 1'b1;
        #1;
        chk("init_last", waiting, 1);

        // Read with two waitrequest cycles and rdvalid five cycles after acceptance
        @(negedge clk); avl_waitreq = 1'b1; #1;
        chk("rd_idle", {waiting, avl_read}, 2'b10);
        @(negedge clk); #1;
        chk("rd_cmd1", {waiting, avl_read}, 2'b11);
        chk("rd_addr", avl_address, 27'h0000123);
        @(negedge clk); #1;
        chk("rd_cmd2", {waiting, avl_read}, 2'b11);
        @(negedge clk); avl_waitreq = 1'b0; #1;
        chk("rd_cmd3", {waiting, avl_read}, 2'b11);
        for (int age = 1; age <= 5; age++) begin
            @(negedge clk);
            if (age == 5) begin
                avl_rdvalid = 1'b1; avl_readdata = 32'hDEADBEEF;
            end
            #1;
            chk("rd_wait", {waiting, avl_read}, 2'b10);
        end
        @(negedge clk);
        avl_rdvalid = 1'b0; avl_readdata = 32'h0BAD0BAD;
        // CPU advances and presents the next request while in DONE
        read_req = 1'b0; write_req = 1'b1; address = 27'h7FFFFFF; write_data = 32'hA5A5A5A5;
        #1;
        chk("rd_done_waiting", waiting, 0);
        chk("rd_data", read_data, 32'hDEADBEEF);

        // Write with no waitrequest
        @(negedge clk); #1;
        chk("wr_idle", {waiting, avl_write, avl_read}, 3'b100);
        @(negedge clk); #1;
        chk("wr_cmd", {waiting, avl_write, avl_read}, 3'b110);
        chk("wr_addr", avl_address, 27'h7FFFFFF);
        chk("wr_data", avl_writedata, 32'hA5A5A5A5);
        @(negedge clk);
        read_req = 1'b1; write_req = 1'b1; address = 27'h0000055; write_data = 32'h12345678;
        #1;
        chk("wr_done", {waiting, avl_write}, 2'b00);

        // Simultaneous requests: write wins
        @(negedge clk); #1;
        chk("both_idle", {waiting, avl_write, avl_read}, 3'b100);
        @(negedge clk); #1;
        chk("both_cmd", {waiting, avl_write, avl_read}, 3'b110);
        chk("both_wdata", avl_writedata, 32'h12345678);
        chk("both_addr", avl_address, 27'h0000055);
        @(negedge clk);
        write_req = 1'b0; address = 27'h0000200;
        #1;
        chk("both_done", {waiting, avl_read}, 2'b00);
        chk("both_rdata", read_data, 32'hDEADBEEF);

        // Timeout: read never answered
        @(negedge clk); #1;
        chk("to_idle", waiting, 1);
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk); #1;
            chk("to_busy", {err, waiting}, 2'b01);
        end
        @(negedge clk);
        read_req = 1'b0;
        #1;
        chk("to_done", {err, waiting, avl_read}, 3'b100);
        chk("to_rdata", read_data, 32'hDEADBEEF);
        repeat (3) @(negedge clk);
        #1;
        chk("to_sticky", {err, waiting}, 2'b10);

        rst = 1'b1;
        @(negedge clk); #1;
        chk("rst2_err", err, 0);
        chk("rst2_rdata", read_data, 0);

`ifdef DDR_RD_CACHE_EN
        // Fill, write-through, then hit
        rst = 1'b0; read_req = 1'b1; address = 27'h0000010;
        @(negedge clk); #1;
        chk("c_idle", waiting, 1);
        @(negedge clk); #1;
        chk("c_cmd", avl_read, 1);
        @(negedge clk); avl_rdvalid = 1'b1; avl_readdata = 32'h00001111; #1;
        @(negedge clk);
        avl_rdvalid = 1'b0; avl_readdata = '0;
        read_req = 1'b0; write_req = 1'b1; write_data = 32'h00002222;
        #1;
        chk("c_fill", read_data, 32'h00001111);
        @(negedge clk); #1;
        @(negedge clk); #1;
        chk("c_wr", avl_write, 1);
        @(negedge clk);
        write_req = 1'b0; read_req = 1'b1;
        #1;
        @(negedge clk); #1;
        chk("c_hit", {waiting, avl_read}, 2'b00);
        chk("c_hit_data", read_data, 32'h00002222);
        read_req = 1'b0;
        @(negedge clk); #1;
        chk("c_after", {avl_read, waiting}, 2'b00);
        chk("c_after_data", read_data, 32'h00002222);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
